// File: rtl/cora16_spi_pkg.sv
// Shared types and constants for the SPI RAM controller.
// Commands, frame size, FSM states and grant owners.
package cora16_spi_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         FRAME_BITS = 48;

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    SHIFT,
    DONE
  } state_t;

  typedef enum logic {
    FETCH,
    DATA
  } grant_t;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic        we,
    input logic [23:0] addr,
    input logic [15:0] wdata
  );
    return {we ? CMD_WRITE : CMD_READ,
            addr,
            we ? wdata : 16'h0000};
  endfunction

endpackage

// File: rtl/spi_mem_shifter.sv
// SPI bit engine: clk divider, 48-bit out shifter, 16-bit capture.
// Ports: load/frame start a frame, run clocks it, done marks the end.
module spi_mem_shifter
  import cora16_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  run,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic                  miso,
  output logic                  mosi,
  output logic                  sclk,
  output logic [15:0]           capture,
  output logic                  done
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);
  localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);

  logic [FRAME_BITS-1:0] sr;
  logic [PW-1:0]         ph;
  logic                  half;
  logic [5:0]            bcnt;
  logic                  wrap;

  assign wrap = (ph == LAST);
  assign mosi = sr[FRAME_BITS-1];
  assign sclk = run && half;
  assign done = run && half && wrap
             && (bcnt == LAST_BIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      ph      <= '0;
      half    <= 1'b0;
      bcnt    <= '0;
      capture <= '0;
    end else if (load) begin
      sr   <= frame;
      ph   <= '0;
      half <= 1'b0;
      bcnt <= '0;
    end else if (run) begin
      if (wrap) begin
        ph   <= '0;
        half <= ~half;
        // low->high: sample miso; high->low: next bit
        if (!half) begin
          capture <= {capture[14:0], miso};
        end else begin
          sr   <= {sr[FRAME_BITS-2:0], 1'b0};
          bcnt <= bcnt + 6'd1;
        end
      end else begin
        ph <= ph + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_mem_ctrl.sv
// SPI RAM controller: arbitrates fetch/data ports onto one SPI RAM.
// Ports: fetch and data req/ready pairs, busy, SPI pins.
module spi_mem_ctrl
  import cora16_spi_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [23:0] fetch_addr,
  output logic        fetch_ready,
  output logic [15:0] fetch_data,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [23:0] data_addr,
  input  logic [15:0] data_wdata,
  output logic        data_ready,
  output logic [15:0] data_rdata,
  output logic        busy,
  output logic        spi_select,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  state_t state, next_state;
  grant_t last_grant, grant_sel;
  logic   grant_ok;
  logic   frame_we;
  logic   we_q;
  logic   done;
  logic   sh_mosi;
  logic   sh_clk;
  logic [15:0] cap;
  logic [23:0] frame_addr;
  logic [FRAME_BITS-1:0] frame;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    grant_ok   = 1'b0;
    grant_sel  = last_grant;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (fetch_req && data_req):
            grant_sel = (last_grant == FETCH)
                      ? DATA : FETCH;
          (fetch_req && !data_req):
            grant_sel = FETCH;
          (!fetch_req && data_req):
            grant_sel = DATA;
          default: ;
        endcase
        grant_ok = fetch_req || data_req;
        if (grant_ok) next_state = SELECT;
      end
      SELECT: next_state = SHIFT;
      SHIFT:  if (done) next_state = DONE;
      DONE:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign frame_we   = (grant_sel == DATA) && data_we;
  assign frame_addr = (grant_sel == FETCH)
                    ? fetch_addr : data_addr;
  assign frame = make_frame(frame_we, frame_addr,
                            data_wdata);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= FETCH;
      we_q       <= 1'b0;
      fetch_data <= '0;
      data_rdata <= '0;
    end else begin
      if (grant_ok) begin
        last_grant <= grant_sel;
        we_q       <= frame_we;
      end
      // load responses so they are valid in DONE
      if (state == SHIFT && done) begin
        if (last_grant == FETCH) begin
          fetch_data <= cap;
        end else if (!we_q) begin
          data_rdata <= cap;
        end
      end
    end
  end

  spi_mem_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (grant_ok),
    .run     (state == SHIFT),
    .frame   (frame),
    .miso    (spi_miso),
    .mosi    (sh_mosi),
    .sclk    (sh_clk),
    .capture (cap),
    .done    (done)
  );

  assign busy        = (state != IDLE);
  assign spi_select  = (state == SELECT)
                    || (state == SHIFT);
  assign spi_clk     = sh_clk;
  assign spi_mosi    = spi_select && sh_mosi;
  assign fetch_ready = (state == DONE)
                    && (last_grant == FETCH);
  assign data_ready  = (state == DONE)
                    && (last_grant == DATA);

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Self-checking bench for spi_mem_ctrl with a behavioural SPI RAM.
// Two instances: CLK_DIV=1 (a) and CLK_DIV=2 (b) share one RAM.
module tb_spi_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b1;
  logic freq_a = 0, dreq_a = 0;
  logic freq_b = 0, dreq_b = 0;
  logic [23:0] f_addr = '0, d_addr = '0;
  logic d_we = 1'b0;
  logic [15:0] d_wdata = '0;
  logic miso = 1'b0;

  logic frdy_a, drdy_a, busy_a, sel_a, sclk_a, mosi_a;
  logic frdy_b, drdy_b, busy_b, sel_b, sclk_b, mosi_b;
  logic [15:0] fdat_a, ddat_a, fdat_b, ddat_b;

  bit sel2 = 1'b0;
  wire m_sel  = sel2 ? sel_b  : sel_a;
  wire m_sclk = sel2 ? sclk_b : sclk_a;
  wire m_mosi = sel2 ? mosi_b : mosi_a;
  wire m_frdy = sel2 ? frdy_b : frdy_a;
  wire m_drdy = sel2 ? drdy_b : drdy_a;
  wire m_busy = sel2 ? busy_b : busy_a;
  wire [15:0] m_fdat = sel2 ? fdat_b : fdat_a;
  wire [15:0] m_ddat = sel2 ? ddat_b : ddat_a;

  spi_mem_ctrl #(.CLK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(freq_a), .fetch_addr(f_addr),
    .fetch_ready(frdy_a), .fetch_data(fdat_a),
    .data_req(dreq_a), .data_we(d_we),
    .data_addr(d_addr), .data_wdata(d_wdata),
    .data_ready(drdy_a), .data_rdata(ddat_a),
    .busy(busy_a), .spi_select(sel_a),
    .spi_clk(sclk_a), .spi_mosi(mosi_a),
    .spi_miso(miso)
  );

  spi_mem_ctrl #(.CLK_DIV(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(freq_b), .fetch_addr(f_addr),
    .fetch_ready(frdy_b), .fetch_data(fdat_b),
    .data_req(dreq_b), .data_we(d_we),
    .data_addr(d_addr), .data_wdata(d_wdata),
    .data_ready(drdy_b), .data_rdata(ddat_b),
    .busy(busy_b), .spi_select(sel_b),
    .spi_clk(sclk_b), .spi_mosi(mosi_b),
    .spi_miso(miso)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural SPI RAM ----------------
  function automatic logic [7:0] init_byte(
    input logic [23:0] a);
    case (a)
      24'h000010: return 8'hAB;
      24'h000011: return 8'hCD;
      default:    return 8'h00;
    endcase
  endfunction

  logic [7:0] ram [logic [23:0]];

  function automatic logic [7:0] ram_rd(
    input logic [23:0] a);
    if (ram.exists(a)) return ram[a];
    return init_byte(a);
  endfunction

  int rcnt = 0;
  logic [47:0] rx = '0;
  logic [31:0] hdr = '0;
  logic [15:0] rword = '0;

  always @(posedge m_sclk or negedge m_sel) begin
    if (!m_sel) begin
      rcnt = 0;
    end else begin
      rx = {rx[46:0], m_mosi};
      rcnt++;
      if (rcnt == 32) begin
        hdr = rx[31:0];
        rword = {ram_rd(rx[23:0]),
                 ram_rd(rx[23:0] + 24'd1)};
      end
      if (rcnt == 48 && rx[47:40] == 8'h02) begin
        ram[rx[39:16]] = rx[15:8];
        ram[rx[39:16] + 24'd1] = rx[7:0];
      end
    end
  end

  always @(negedge m_sclk) begin
    if (rcnt >= 32 && rcnt < 48 && hdr[31:24] == 8'h03)
      miso = rword[47-rcnt];
    else
      miso = 1'($urandom);
  end

  // ---------------- monitors ----------------
  int cyc = 0;
  always @(posedge clk) cyc++;

  int last_rise = 0, sclk_per = 0;
  always @(posedge m_sclk) begin
    sclk_per = cyc - last_rise;
    last_rise = cyc;
  end

  int srun = 0, sel_w = 0;
  always @(negedge clk) begin
    if (m_sel) srun++;
    else if (srun != 0) begin
      sel_w = srun;
      srun = 0;
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] refm [logic [23:0]];

  function automatic logic [7:0] ref_b(
    input logic [23:0] a);
    if (refm.exists(a)) return refm[a];
    return (a == 24'h10) ? 8'hAB :
           (a == 24'h11) ? 8'hCD : 8'h00;
  endfunction

  function automatic logic [15:0] ref_word(
    input logic [23:0] a);
    return {ref_b(a), ref_b(a + 24'd1)};
  endfunction

  task automatic ref_write(input logic [23:0] a,
                           input logic [15:0] w);
    refm[a] = w[15:8];
    refm[a + 24'd1] = w[7:0];
  endtask

  // ---------------- transaction driver ----------------
  task automatic txn(input bit port, input bit we,
                     input logic [23:0] addr,
                     input logic [15:0] wd,
                     output logic [15:0] rd,
                     output int lat);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    f_addr = addr; d_addr = addr;
    d_we = we; d_wdata = wd;
    if (port) begin
      if (sel2) dreq_b = 1; else dreq_a = 1;
    end else begin
      if (sel2) freq_b = 1; else freq_a = 1;
    end
    @(posedge clk);
    lat = 0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      #1;
      if (port ? m_drdy : m_frdy) ok = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    freq_a = 0; dreq_a = 0;
    freq_b = 0; dreq_b = 0;
    rd = port ? m_ddat : m_fdat;
    chk("ready_seen", 64'(ok), 1);
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    bit          port;
    bit          we;
    logic [23:0] addr;
    logic [15:0] wd;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [7];
  logic [23:0] pool [6];
  logic [15:0] rd, exp_f, exp_d, w16;
  logic [23:0] a24;
  int lat, hi, rp, w, idl;
  bit rr_last, rr_exp, got, p, we;

  initial begin
    tbl[0] = '{0, 0, 24'h000010, 16'h0000, 16'hABCD};
    tbl[1] = '{1, 1, 24'h000100, 16'h1234, 16'h0000};
    tbl[2] = '{1, 0, 24'h000100, 16'h0000, 16'h1234};
    tbl[3] = '{0, 0, 24'h000100, 16'h0000, 16'h1234};
    tbl[4] = '{1, 1, 24'hFFFFFF, 16'hBEEF, 16'h1234};
    tbl[5] = '{1, 0, 24'hFFFFFF, 16'h0000, 16'hBEEF};
    tbl[6] = '{0, 0, 24'h000000, 16'h0000, 16'hEF00};
    pool[0] = 24'h000000; pool[1] = 24'h000100;
    pool[2] = 24'h000101; pool[3] = 24'h7FFFFE;
    pool[4] = 24'hFFFFFF; pool[5] = 24'h123456;

    // reset state
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_a", {sel_a, sclk_a, mosi_a, busy_a,
        frdy_a, drdy_a, fdat_a, ddat_a}, 0);
    chk("reset_out_b", {sel_b, sclk_b, mosi_b, busy_b,
        frdy_b, drdy_b, fdat_b, ddat_b}, 0);
    @(negedge clk) rst_n = 1'b1;
    hi = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy_a | sel_a | m_busy) hi++;
    end
    chk("idle_quiet", hi, 0);

    // arbitration: both requests held from reset
    rst_n = 1'b0;
    f_addr = 24'h10; d_addr = 24'h100; d_we = 0;
    freq_a = 1; dreq_a = 1;
    @(negedge clk) rst_n = 1'b1;
    rr_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w = 0; idl = 0; got = 0;
      while (!got && w < 500) begin
        @(posedge clk);
        #1;
        w++;
        if (frdy_a | drdy_a) got = 1;
        else if (!busy_a) idl++;
      end
      rr_exp = ~rr_last;
      rr_last = rr_exp;
      chk("arb_grant", {frdy_a, drdy_a},
          rr_exp ? 2'b01 : 2'b10);
      if (k > 0) begin
        chk("arb_gap", w, 3 + 96);
        chk("arb_idle", idl, 1);
      end
    end
    freq_a = 0; dreq_a = 0;
    @(negedge clk);
    #1;
    exp_f = ref_word(24'h10);
    exp_d = ref_word(24'h100);

    // directed table
    foreach (tbl[i]) begin
      txn(tbl[i].port, tbl[i].we, tbl[i].addr,
          tbl[i].wd, rd, lat);
      chk("tbl_lat", lat, 1 + 96);
      chk("tbl_selw", sel_w, 1 + 96);
      chk("tbl_hdr", hdr,
          {tbl[i].we ? 8'h02 : 8'h03, tbl[i].addr});
      chk("tbl_data", tbl[i].we ? m_ddat : rd,
          tbl[i].exp);
      if (tbl[i].we) begin
        ref_write(tbl[i].addr, tbl[i].wd);
        chk("tbl_ram", {ram_rd(tbl[i].addr),
            ram_rd(tbl[i].addr + 24'd1)}, tbl[i].wd);
      end
    end
    exp_f = ref_word(24'h0);
    exp_d = ref_word(24'hFFFFFF);

    // reset in the middle of a frame
    @(posedge clk);
    #1;
    f_addr = 24'h10; freq_a = 1;
    @(posedge clk);
    repeat (41) @(posedge clk);
    #2;
    chk("mid_sel", sel_a, 1);
    rst_n = 1'b0; freq_a = 0;
    #1;
    chk("abort_pins", {sel_a, sclk_a, mosi_a, busy_a}, 0);
    rp = 0;
    repeat (4) begin
      @(negedge clk);
      if (frdy_a | drdy_a) rp++;
    end
    chk("abort_noready", rp, 0);
    chk("abort_clear", {fdat_a, ddat_a}, 0);
    rst_n = 1'b1;
    exp_f = 16'h0; exp_d = 16'h0;
    txn(1, 0, 24'h10, 16'h0, rd, lat);
    chk("abort_reread", rd, 16'hABCD);
    exp_d = 16'hABCD;

    // random traffic against the reference model
    for (int n = 0; n < 30; n++) begin
      p = 1'($urandom);
      we = p && 1'($urandom);
      a24 = pool[$urandom_range(0, 5)];
      w16 = 16'($urandom);
      txn(p, we, a24, w16, rd, lat);
      chk("rnd_lat", lat, 1 + 96);
      chk("rnd_hdr", hdr, {we ? 8'h02 : 8'h03, a24});
      if (we) begin
        ref_write(a24, w16);
        chk("rnd_whold", m_ddat, exp_d);
      end else if (p) begin
        exp_d = ref_word(a24);
        chk("rnd_dread", rd, exp_d);
      end else begin
        exp_f = ref_word(a24);
        chk("rnd_fetch", rd, exp_f);
        chk("rnd_dhold", m_ddat, exp_d);
      end
    end

    // divided SPI clock
    sel2 = 1'b1;
    txn(0, 0, 24'h10, 16'h0, rd, lat);
    chk("div2_lat", lat, 1 + 96 * 2);
    chk("div2_data", rd, 16'hABCD);
    chk("div2_per", sclk_per, 4);
    chk("div2_selw", sel_w, 1 + 96 * 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
